// File: rtl/ace_pkg.sv
// ace_pkg: shared definitions for the ACE snoop path.
//   - Snoop opcode constants carried on the AC channel (ac_snoop).
//   - cr_resp_t: packed CR response {WasUnique, IsShared, PassDirty, Error, DataTransfer}.
//   - RESP_* bit positions of the same fields in a flat 5-bit response.
//   - snp_state_t: snoop responder FSM states.
package ace_pkg;

  localparam logic [3:0] SNP_READ_ONCE       = 4'b0000;
  localparam logic [3:0] SNP_READ_SHARED     = 4'b0001;
  localparam logic [3:0] SNP_READ_CLEAN      = 4'b0010;
  localparam logic [3:0] SNP_READ_NOT_SH_DTY = 4'b0011;
  localparam logic [3:0] SNP_READ_UNIQUE     = 4'b0111;
  localparam logic [3:0] SNP_CLEAN_SHARED    = 4'b1000;
  localparam logic [3:0] SNP_CLEAN_INVALID   = 4'b1001;
  localparam logic [3:0] SNP_MAKE_INVALID    = 4'b1101;

  localparam int RESP_WU  = 4;
  localparam int RESP_IS  = 3;
  localparam int RESP_PD  = 2;
  localparam int RESP_ERR = 1;
  localparam int RESP_DT  = 0;

  typedef struct packed {
    logic was_unique;
    logic is_shared;
    logic pass_dirty;
    logic error;
    logic data_transfer;
  } cr_resp_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_WAIT,
    ST_UPDATE,
    ST_RESP,
    ST_DATA
  } snp_state_t;

endpackage

// File: rtl/ace_snoop_decode.sv
// ace_snoop_decode: combinational snoop decode.
// Maps (opcode, lookup hit/dirty/shared) to the CR response and to the local
// line-state change.
//   snoop_i       in   snoop opcode
//   hit_i         in   line present
//   dirty_i       in   line dirty
//   shared_i      in   line shared
//   resp_o        out  CR response fields
//   invalidate_o  out  line must be invalidated
//   clean_o       out  line must be marked clean and shared
module ace_snoop_decode
  import ace_pkg::*;
(
  input  logic [3:0] snoop_i,
  input  logic       hit_i,
  input  logic       dirty_i,
  input  logic       shared_i,
  output cr_resp_t   resp_o,
  output logic       invalidate_o,
  output logic       clean_o
);

  // A miss on a known opcode leaves everything zero; unknown opcodes report
  // Error whatever the lookup returned.
  always_comb begin
    resp_o       = '0;
    invalidate_o = 1'b0;
    clean_o      = 1'b0;
    case (snoop_i)
      SNP_READ_ONCE: begin
        if (hit_i) begin
          resp_o.was_unique    = !shared_i;
          resp_o.is_shared     = 1'b1;
          resp_o.data_transfer = 1'b1;
        end
      end
      SNP_READ_SHARED, SNP_READ_CLEAN, SNP_READ_NOT_SH_DTY: begin
        if (hit_i) begin
          resp_o.was_unique    = !shared_i;
          resp_o.is_shared     = 1'b1;
          resp_o.pass_dirty    = dirty_i;
          resp_o.data_transfer = 1'b1;
          clean_o              = dirty_i;
        end
      end
      SNP_READ_UNIQUE: begin
        if (hit_i) begin
          resp_o.was_unique    = !shared_i;
          resp_o.pass_dirty    = dirty_i;
          resp_o.data_transfer = 1'b1;
          invalidate_o         = 1'b1;
        end
      end
      SNP_CLEAN_INVALID: begin
        if (hit_i) begin
          resp_o.was_unique    = !shared_i;
          resp_o.pass_dirty    = dirty_i;
          resp_o.data_transfer = dirty_i;
          invalidate_o         = 1'b1;
        end
      end
      SNP_CLEAN_SHARED: begin
        if (hit_i) begin
          resp_o.was_unique    = !shared_i;
          resp_o.is_shared     = 1'b1;
          resp_o.pass_dirty    = dirty_i;
          resp_o.data_transfer = dirty_i;
          clean_o              = dirty_i;
        end
      end
      SNP_MAKE_INVALID: begin
        if (hit_i) begin
          invalidate_o = 1'b1;
        end
      end
      default: begin
        resp_o.error = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/ace_snoop_responder.sv
// ace_snoop_responder: cache-side ACE snoop endpoint.
// Accepts one AC snoop, looks the line up in the local data cache, applies the
// required state change, returns CR and, when DataTransfer is set, streams the
// line on CD beat 0 first.
//   clk_i, rst_i                      clock, synchronous active-high reset
//   ac_valid_i/ac_ready_o/ac_addr_i/ac_snoop_i   snoop request
//   cr_valid_o/cr_ready_i/cr_resp_o              snoop response
//   cd_valid_o/cd_ready_i/cd_data_o/cd_last_o    snoop data
//   lookup_req_o/lookup_addr_o/lookup_gnt_i      cache lookup request
//   lookup_rvalid_i/lookup_hit_i/lookup_dirty_i/lookup_shared_i/lookup_data_i
//                                                cache lookup result
//   upd_valid_o/upd_invalidate_o/upd_clean_o/upd_ready_i  line-state update
module ace_snoop_responder
  import ace_pkg::*;
#(
  parameter int AddrWidth       = 64,
  parameter int DataWidth       = 64,
  parameter int DcacheLineWidth = 512
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       ac_valid_i,
  output logic                       ac_ready_o,
  input  logic [AddrWidth-1:0]       ac_addr_i,
  input  logic [3:0]                 ac_snoop_i,
  output logic                       cr_valid_o,
  input  logic                       cr_ready_i,
  output logic [4:0]                 cr_resp_o,
  output logic                       cd_valid_o,
  input  logic                       cd_ready_i,
  output logic [DataWidth-1:0]       cd_data_o,
  output logic                       cd_last_o,
  output logic                       lookup_req_o,
  output logic [AddrWidth-1:0]       lookup_addr_o,
  input  logic                       lookup_gnt_i,
  input  logic                       lookup_rvalid_i,
  input  logic                       lookup_hit_i,
  input  logic                       lookup_dirty_i,
  input  logic                       lookup_shared_i,
  input  logic [DcacheLineWidth-1:0] lookup_data_i,
  output logic                       upd_valid_o,
  output logic                       upd_invalidate_o,
  output logic                       upd_clean_o,
  input  logic                       upd_ready_i
);

  localparam int Beats  = DcacheLineWidth / DataWidth;
  localparam int BeatW  = (Beats > 1) ? $clog2(Beats) : 1;
  localparam int OffW   = $clog2(DcacheLineWidth / 8);
  localparam logic [BeatW-1:0] LastBeat = BeatW'(Beats - 1);
  localparam logic [AddrWidth-1:0] LineMask =
    {{(AddrWidth - OffW){1'b1}}, {OffW{1'b0}}};

  snp_state_t                 state_q;
  logic [AddrWidth-1:0]       addr_q;
  logic [3:0]                 snoop_q;
  cr_resp_t                   resp_q;
  logic                       inv_q;
  logic                       clean_q;
  logic [DcacheLineWidth-1:0] line_q;
  logic [BeatW-1:0]           beat_q;

  cr_resp_t dec_resp;
  logic     dec_inv;
  logic     dec_clean;

  ace_snoop_decode u_decode (
    .snoop_i      (snoop_q),
    .hit_i        (lookup_hit_i),
    .dirty_i      (lookup_dirty_i),
    .shared_i     (lookup_shared_i),
    .resp_o       (dec_resp),
    .invalidate_o (dec_inv),
    .clean_o      (dec_clean)
  );

  // All handshake outputs come straight from state/registered payload, so
  // they cannot change until the state advances on the matching handshake.
  assign ac_ready_o       = (state_q == ST_IDLE) && !rst_i;
  assign lookup_req_o     = (state_q == ST_LOOKUP);
  assign lookup_addr_o    = addr_q;
  assign upd_valid_o      = (state_q == ST_UPDATE);
  assign upd_invalidate_o = inv_q;
  assign upd_clean_o      = clean_q;
  assign cr_valid_o       = (state_q == ST_RESP);
  assign cr_resp_o        = resp_q;
  assign cd_valid_o       = (state_q == ST_DATA);
  assign cd_data_o        = line_q[int'(beat_q) * DataWidth +: DataWidth];
  assign cd_last_o        = (state_q == ST_DATA) && (beat_q == LastBeat);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      snoop_q <= '0;
      resp_q  <= '0;
      inv_q   <= 1'b0;
      clean_q <= 1'b0;
      line_q  <= '0;
      beat_q  <= '0;
    end else begin
      case (state_q)
        // request capture
        ST_IDLE: begin
          if (ac_valid_i) begin
            addr_q  <= ac_addr_i & LineMask;
            snoop_q <= ac_snoop_i;
            state_q <= ST_LOOKUP;
          end
        end
        // cache lookup
        ST_LOOKUP: begin
          if (lookup_gnt_i) begin
            state_q <= ST_WAIT;
          end
        end
        // lookup result and decode
        ST_WAIT: begin
          if (lookup_rvalid_i) begin
            resp_q  <= dec_resp;
            inv_q   <= dec_inv;
            clean_q <= dec_clean;
            line_q  <= lookup_data_i;
            beat_q  <= '0;
            state_q <= (dec_inv || dec_clean) ? ST_UPDATE : ST_RESP;
          end
        end
        // line-state change
        ST_UPDATE: begin
          if (upd_ready_i) begin
            state_q <= ST_RESP;
          end
        end
        // CR response
        ST_RESP: begin
          if (cr_ready_i) begin
            state_q <= resp_q.data_transfer ? ST_DATA : ST_IDLE;
          end
        end
        // CD beats
        ST_DATA: begin
          if (cd_ready_i) begin
            if (beat_q == LastBeat) begin
              state_q <= ST_IDLE;
            end else begin
              beat_q <= beat_q + BeatW'(1);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ace_snoop_responder.sv
module tb_ace_snoop_responder;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         ac_valid_i;
  logic         ac_ready_o;
  logic [63:0]  ac_addr_i;
  logic [3:0]   ac_snoop_i;
  logic         cr_valid_o;
  logic         cr_ready_i;
  logic [4:0]   cr_resp_o;
  logic         cd_valid_o;
  logic         cd_ready_i;
  logic [63:0]  cd_data_o;
  logic         cd_last_o;
  logic         lookup_req_o;
  logic [63:0]  lookup_addr_o;
  logic         lookup_gnt_i;
  logic         lookup_rvalid_i;
  logic         lookup_hit_i;
  logic         lookup_dirty_i;
  logic         lookup_shared_i;
  logic [511:0] lookup_data_i;
  logic         upd_valid_o;
  logic         upd_invalidate_o;
  logic         upd_clean_o;
  logic         upd_ready_i;

  ace_snoop_responder dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .ac_valid_i       (ac_valid_i),
    .ac_ready_o       (ac_ready_o),
    .ac_addr_i        (ac_addr_i),
    .ac_snoop_i       (ac_snoop_i),
    .cr_valid_o       (cr_valid_o),
    .cr_ready_i       (cr_ready_i),
    .cr_resp_o        (cr_resp_o),
    .cd_valid_o       (cd_valid_o),
    .cd_ready_i       (cd_ready_i),
    .cd_data_o        (cd_data_o),
    .cd_last_o        (cd_last_o),
    .lookup_req_o     (lookup_req_o),
    .lookup_addr_o    (lookup_addr_o),
    .lookup_gnt_i     (lookup_gnt_i),
    .lookup_rvalid_i  (lookup_rvalid_i),
    .lookup_hit_i     (lookup_hit_i),
    .lookup_dirty_i   (lookup_dirty_i),
    .lookup_shared_i  (lookup_shared_i),
    .lookup_data_i    (lookup_data_i),
    .upd_valid_o      (upd_valid_o),
    .upd_invalidate_o (upd_invalidate_o),
    .upd_clean_o      (upd_clean_o),
    .upd_ready_i      (upd_ready_i)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int upd_cnt  = 0;

  logic [4:0]  exp_cr_q[$];
  logic [63:0] exp_cd_q[$];
  logic        exp_last_q[$];
  logic        exp_inv;
  logic        exp_clean;

  logic        cd_hold;
  logic [63:0] cd_hold_data;

  always @(posedge clk_i) cyc++;

  // Expected CR response from the opcode table.
  function automatic logic [4:0] model_resp(input logic [3:0] op, input logic hit,
                                            input logic dirty, input logic shared);
    logic wu;
    wu = ~shared;
    case (op)
      4'b0000:                   return hit ? {wu, 1'b1, 1'b0, 1'b0, 1'b1} : 5'b00000;
      4'b0001, 4'b0010, 4'b0011: return hit ? {wu, 1'b1, dirty, 1'b0, 1'b1} : 5'b00000;
      4'b0111:                   return hit ? {wu, 1'b0, dirty, 1'b0, 1'b1} : 5'b00000;
      4'b1001:                   return hit ? {wu, 1'b0, dirty, 1'b0, dirty} : 5'b00000;
      4'b1000:                   return hit ? {wu, 1'b1, dirty, 1'b0, dirty} : 5'b00000;
      4'b1101:                   return 5'b00000;
      default:                   return 5'b00010;
    endcase
  endfunction

  // Expected {invalidate, clean}.
  function automatic logic [1:0] model_upd(input logic [3:0] op, input logic hit,
                                           input logic dirty);
    if (!hit) return 2'b00;
    case (op)
      4'b0001, 4'b0010, 4'b0011, 4'b1000: return {1'b0, dirty};
      4'b0111, 4'b1001, 4'b1101:          return 2'b10;
      default:                            return 2'b00;
    endcase
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Handshake monitor / scoreboard consumer.
  always @(negedge clk_i) begin
    if (rst_i) begin
      cd_hold = 1'b0;
    end else begin
      if (cr_valid_o && cr_ready_i) begin
        n_checks++;
        if (exp_cr_q.size() == 0) begin
          n_fail++;
          $display("FAIL cr_unexpected got=%b want=none", cr_resp_o);
        end else begin
          logic [4:0] e;
          e = exp_cr_q.pop_front();
          if (cr_resp_o !== e) begin
            n_fail++;
            $display("FAIL cr_resp got=%b want=%b", cr_resp_o, e);
          end
        end
      end
      if (cd_hold) begin
        n_checks++;
        if (cd_valid_o !== 1'b1 || cd_data_o !== cd_hold_data) begin
          n_fail++;
          $display("FAIL cd_stall_stable got=%b/%h want=1/%h", cd_valid_o, cd_data_o, cd_hold_data);
        end
      end
      if (cd_valid_o && cd_ready_i) begin
        n_checks++;
        if (exp_cd_q.size() == 0) begin
          n_fail++;
          $display("FAIL cd_unexpected got=%h want=none", cd_data_o);
        end else begin
          logic [63:0] ed;
          logic        el;
          ed = exp_cd_q.pop_front();
          el = exp_last_q.pop_front();
          if (cd_data_o !== ed || cd_last_o !== el) begin
            n_fail++;
            $display("FAIL cd_beat got=%h last=%b want=%h last=%b", cd_data_o, cd_last_o, ed, el);
          end
        end
      end
      if (upd_valid_o && upd_ready_i) begin
        upd_cnt++;
        n_checks++;
        if ({upd_invalidate_o, upd_clean_o} !== {exp_inv, exp_clean}) begin
          n_fail++;
          $display("FAIL upd_flags got=%b want=%b", {upd_invalidate_o, upd_clean_o}, {exp_inv, exp_clean});
        end
      end
      cd_hold      = cd_valid_o && !cd_ready_i;
      cd_hold_data = cd_data_o;
    end
  end

  function automatic logic [511:0] byte_ramp();
    logic [511:0] l;
    for (int i = 0; i < 64; i++) l[i*8 +: 8] = 8'(i);
    return l;
  endfunction

  function automatic logic [511:0] rand_line();
    logic [511:0] l;
    for (int i = 0; i < 16; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  // One complete snoop: drives AC, serves the lookup, drains CR/CD.
  // exp_lat: clock edges from the AC handshake to cr_valid_o (-1 = unchecked).
  task automatic snoop(input logic [3:0] op, input logic [63:0] addr,
                       input logic hit, input logic dirty, input logic shared,
                       input logic [511:0] line, input int gnt_dly, input int cr_dly,
                       input bit cd_toggle, input int exp_lat);
    logic [4:0]  e;
    logic [1:0]  u;
    logic [63:0] la;
    int          n;
    int          c0;
    int          upd0;
    e = model_resp(op, hit, dirty, shared);
    u = model_upd(op, hit, dirty);
    exp_cr_q.push_back(e);
    if (e[0]) begin
      for (int b = 0; b < 8; b++) begin
        exp_cd_q.push_back(line[b*64 +: 64]);
        exp_last_q.push_back(b == 7);
      end
    end
    exp_inv   = u[1];
    exp_clean = u[0];
    upd0      = upd_cnt;
    la        = {addr[63:6], 6'b0};

    ac_valid_i = 1'b1;
    ac_addr_i  = addr;
    ac_snoop_i = op;
    n = 0;
    while (!ac_ready_o && n < 50) begin step(); n++; end
    if (!ac_ready_o) begin
      n_checks++; n_fail++;
      $display("FAIL ac_ready_timeout got=0 want=1");
    end
    step();
    c0 = cyc;
    ac_valid_i = 1'b0;
    ac_addr_i  = ~addr;
    ac_snoop_i = ~op;

    n = 0;
    while (!lookup_req_o && n < 20) begin step(); n++; end
    n_checks++;
    if (lookup_req_o !== 1'b1 || lookup_addr_o !== la) begin
      n_fail++;
      $display("FAIL lookup_req got=%b/%h want=1/%h", lookup_req_o, lookup_addr_o, la);
    end
    for (int i = 0; i < gnt_dly; i++) begin
      step();
      n_checks++;
      if (lookup_req_o !== 1'b1 || lookup_addr_o !== la) begin
        n_fail++;
        $display("FAIL lookup_hold got=%b/%h want=1/%h", lookup_req_o, lookup_addr_o, la);
      end
    end
    lookup_gnt_i = 1'b1;
    step();
    lookup_gnt_i    = 1'b0;
    lookup_rvalid_i = 1'b1;
    lookup_hit_i    = hit;
    lookup_dirty_i  = dirty;
    lookup_shared_i = shared;
    lookup_data_i   = line;
    step();
    lookup_rvalid_i = 1'b0;
    lookup_hit_i    = 1'b0;
    lookup_dirty_i  = 1'b0;
    lookup_shared_i = 1'b0;
    lookup_data_i   = '0;

    n = 0;
    while (!cr_valid_o && n < 20) begin step(); n++; end
    if (exp_lat >= 0) begin
      n_checks++;
      if (cyc - c0 != exp_lat) begin
        n_fail++;
        $display("FAIL cr_latency got=%0d want=%0d", cyc - c0, exp_lat);
      end
    end
    for (int i = 0; i < cr_dly; i++) begin
      n_checks++;
      if (cr_valid_o !== 1'b1 || cr_resp_o !== e) begin
        n_fail++;
        $display("FAIL cr_hold got=%b/%b want=1/%b", cr_valid_o, cr_resp_o, e);
      end
      step();
    end
    cr_ready_i = 1'b1;
    step();
    cr_ready_i = 1'b0;

    if (e[0]) begin
      n = 0;
      while (exp_cd_q.size() > 0 && n < 100) begin
        cd_ready_i = cd_toggle ? ~cd_ready_i : 1'b1;
        step();
        n++;
      end
      cd_ready_i = 1'b0;
    end
    n_checks++;
    if (ac_ready_o !== 1'b1 || cd_valid_o !== 1'b0 || cr_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL end_state got=ac%b cd%b cr%b want=ac1 cd0 cr0", ac_ready_o, cd_valid_o, cr_valid_o);
    end
    n_checks++;
    if (upd_cnt - upd0 != int'(u != 2'b00)) begin
      n_fail++;
      $display("FAIL upd_count got=%0d want=%0d", upd_cnt - upd0, int'(u != 2'b00));
    end
    n_checks++;
    if (exp_cr_q.size() != 0 || exp_cd_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending got=%0d/%0d want=0/0", exp_cr_q.size(), exp_cd_q.size());
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) step();
    n_checks++;
    if ({ac_ready_o, cr_valid_o, cd_valid_o, lookup_req_o, upd_valid_o} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_valids got=%b want=00000",
               {ac_ready_o, cr_valid_o, cd_valid_o, lookup_req_o, upd_valid_o});
    end
    n_checks++;
    if (cr_resp_o !== 5'b0 || cd_data_o !== 64'b0 || lookup_addr_o !== 64'b0 || cd_last_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_data got=%b/%h/%h want=0/0/0", cr_resp_o, cd_data_o, lookup_addr_o);
    end
    rst_i = 1'b0;
    step();
    n_checks++;
    if (ac_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready got=%b want=1", ac_ready_o);
    end
  endtask

  task automatic test_read_shared();
    snoop(4'b0001, 64'h0000_1000_0000_1047, 1'b1, 1'b1, 1'b0, byte_ramp(), 0, 0, 1'b0, 3);
  endtask

  task automatic test_read_unique();
    snoop(4'b0111, 64'h0000_0000_2000_0080, 1'b1, 1'b0, 1'b1, rand_line(), 0, 0, 1'b0, 3);
  endtask

  task automatic test_clean_invalid();
    snoop(4'b1001, 64'h0000_0000_3000_00C5, 1'b1, 1'b0, 1'b0, rand_line(), 0, 0, 1'b0, 3);
  endtask

  task automatic test_read_once_latency();
    snoop(4'b0000, 64'h0000_0000_4000_0010, 1'b1, 1'b1, 1'b0, rand_line(), 0, 0, 1'b0, 2);
  endtask

  task automatic test_miss();
    logic [3:0] ops[6] = '{4'b0000, 4'b0001, 4'b0111, 4'b1001, 4'b1000, 4'b1101};
    foreach (ops[i]) snoop(ops[i], 64'h5000 + 64'(i) * 64'h40, 1'b0, 1'b1, 1'b0, rand_line(), 0, 0, 1'b0, 2);
  endtask

  task automatic test_error_opcode();
    snoop(4'b0101, 64'h0000_0000_6000_0000, 1'b1, 1'b1, 1'b0, rand_line(), 0, 1, 1'b0, 2);
  endtask

  task automatic test_backpressure();
    snoop(4'b0001, 64'h0000_0000_7000_0040, 1'b1, 1'b0, 1'b1, rand_line(), 3, 4, 1'b1, -1);
  endtask

  task automatic test_back_to_back();
    logic [3:0] ops[8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0111, 4'b1000, 4'b1001, 4'b1101};
    for (int i = 0; i < 10; i++) begin
      snoop(ops[$urandom_range(0, 7)], {$urandom, $urandom}, 1'($urandom), 1'($urandom),
            1'($urandom), rand_line(), $urandom_range(0, 2), $urandom_range(0, 2),
            1'($urandom), -1);
    end
  endtask

  task automatic test_reset_mid_data();
    logic [511:0] line;
    int           n;
    line = rand_line();
    exp_cr_q.push_back(model_resp(4'b0000, 1'b1, 1'b0, 1'b0));
    for (int b = 0; b < 8; b++) begin
      exp_cd_q.push_back(line[b*64 +: 64]);
      exp_last_q.push_back(b == 7);
    end
    ac_valid_i = 1'b1; ac_addr_i = 64'h8000; ac_snoop_i = 4'b0000;
    step();
    ac_valid_i = 1'b0;
    lookup_gnt_i = 1'b1;
    step();
    lookup_gnt_i = 1'b0;
    lookup_rvalid_i = 1'b1; lookup_hit_i = 1'b1; lookup_data_i = line;
    step();
    lookup_rvalid_i = 1'b0; lookup_hit_i = 1'b0; lookup_data_i = '0;
    n = 0;
    while (!cr_valid_o && n < 20) begin step(); n++; end
    cr_ready_i = 1'b1;
    step();
    cr_ready_i = 1'b0;
    cd_ready_i = 1'b1;
    repeat (3) step();
    cd_ready_i = 1'b0;
    n_checks++;
    if (cd_valid_o !== 1'b1 || cd_data_o !== line[3*64 +: 64] || exp_cd_q.size() != 5) begin
      n_fail++;
      $display("FAIL beat3_present got=%b/%h/%0d want=1/%h/5", cd_valid_o, cd_data_o,
               exp_cd_q.size(), line[3*64 +: 64]);
    end
    rst_i = 1'b1;
    step();
    n_checks++;
    if ({ac_ready_o, cr_valid_o, cd_valid_o, lookup_req_o, upd_valid_o} !== 5'b0) begin
      n_fail++;
      $display("FAIL midreset_valids got=%b want=00000",
               {ac_ready_o, cr_valid_o, cd_valid_o, lookup_req_o, upd_valid_o});
    end
    rst_i = 1'b0;
    exp_cd_q.delete();
    exp_last_q.delete();
    step();
    n_checks++;
    if (cd_valid_o !== 1'b0 || ac_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_idle got=cd%b ac%b want=cd0 ac1", cd_valid_o, ac_ready_o);
    end
    snoop(4'b0000, 64'h0000_0000_9000_0008, 1'b1, 1'b0, 1'b1, rand_line(), 0, 0, 1'b0, 2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1; ac_valid_i = 1'b0; ac_addr_i = '0; ac_snoop_i = '0;
    cr_ready_i = 1'b0; cd_ready_i = 1'b0; lookup_gnt_i = 1'b0; lookup_rvalid_i = 1'b0;
    lookup_hit_i = 1'b0; lookup_dirty_i = 1'b0; lookup_shared_i = 1'b0; lookup_data_i = '0;
    upd_ready_i = 1'b1; cd_hold = 1'b0; cd_hold_data = '0; exp_inv = 1'b0; exp_clean = 1'b0;
    #1;
    test_reset();
    test_read_shared();
    test_read_unique();
    test_clean_invalid();
    test_read_once_latency();
    test_miss();
    test_error_opcode();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_data();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
